// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage RV32 pipeline. Each cycle it
// decides which pipeline registers load and which take a bubble. It also
// launches multi-cycle mul/div ops in EX and waits for them to finish.
//
// Fixed priority in RUN: taken branch, then mul/div launch, then load-use,
// then fetch wait. In MD_WAIT the front of the pipe is frozen until md_done
// arrives or the timeout expires.
//
// Ports:
//   clk, rstn                   clock; synchronous active-low reset
//   id_rs1/id_rs2, id_uses_*    source operands of the instruction in ID
//   ex_rd, ex_is_load           destination and load flag of the EX instruction
//   ex_md_op, ex_branch_taken   EX holds a mul/div op / resolved a taken branch
//   md_done                     one-cycle pulse: mul/div result is valid
//   imem_ready                  fetch data is valid this cycle
//   *_en                        pipeline register load enables
//   *_flush                     load a bubble (NOP) instead of data
//   md_start                    one-cycle pulse that launches the mul/div unit
//   md_timeout                  sticky: a mul/div op hit MD_TIMEOUT
//   stall_cycles                saturating count of cycles with pc_en = 0
//   state                       debug: 0 = RUN, 1 = MD_WAIT
//
// Handshake: md_start is a single-cycle request. The unit answers with a
// single-cycle md_done. There is no backpressure in either direction. A
// missing md_done is covered by the MD_TIMEOUT forced release.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_md_op,
    input  logic             ex_branch_taken,
    input  logic             md_done,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             md_start,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             state
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Value of md_cnt during the last permitted MD_WAIT cycle.
    localparam logic [7:0] MD_LAST = 8'(MD_TIMEOUT - 1);

    state_t     st, st_nxt;
    logic [7:0] md_cnt, md_cnt_nxt;
    logic       timeout_set;
    logic       load_use;

    // A load into x0 never creates a dependency.
    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign state = st;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_start     = 1'b0;
        st_nxt       = st;
        md_cnt_nxt   = md_cnt;
        timeout_set  = 1'b0;

        if (!rstn) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            st_nxt       = RUN;
            md_cnt_nxt   = 8'd0;
        end else begin
            case (st)
                RUN: begin
                    if (ex_branch_taken) begin
                        // A redirect squashes everything younger, including any
                        // md op that is illegally paired with it.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_md_op) begin
                        md_start     = 1'b1;
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        st_nxt       = MD_WAIT;
                        md_cnt_nxt   = 8'd0;
                    end else if (load_use) begin
                        // One bubble only: the load moves on to MEM next cycle.
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (!imem_ready) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        // A result wins over a coincident timeout.
                        st_nxt     = RUN;
                        md_cnt_nxt = 8'd0;
                    end else if (md_cnt == MD_LAST) begin
                        st_nxt      = RUN;
                        md_cnt_nxt  = 8'd0;
                        timeout_set = 1'b1;
                    end else begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        md_cnt_nxt   = md_cnt + 8'd1;
                    end
                end
                default: st_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st           <= RUN;
            md_cnt       <= 8'd0;
            md_timeout   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            st     <= st_nxt;
            md_cnt <= md_cnt_nxt;
            if (timeout_set)
                md_timeout <= 1'b1;
            if (!pc_en && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_md_op;
    logic          ex_branch_taken, md_done, imem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, md_start, md_timeout;
    logic [CW-1:0] stall_cycles;
    logic          state;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_md_op(ex_md_op),
        .ex_branch_taken(ex_branch_taken), .md_done(md_done),
        .imem_ready(imem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .md_start(md_start),
        .md_timeout(md_timeout), .stall_cycles(stall_cycles), .state(state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks whether a mul/div op is outstanding and how many wait
    // cycles it has used up. Expected outputs are written as a bit vector:
    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl, md_start}
    bit m_busy   = 1'b0;
    int m_waited = 0;
    bit m_sticky = 1'b0;
    int m_stall  = 0;

    localparam logic [8:0] V_RESET  = 9'b00000_111_0;
    localparam logic [8:0] V_GO     = 9'b11111_000_0;
    localparam logic [8:0] V_REDIR  = 9'b11111_110_0;
    localparam logic [8:0] V_MDHOLD = 9'b00011_001_0;
    localparam logic [8:0] V_LUSE   = 9'b00111_010_0;
    localparam logic [8:0] V_FETCH  = 9'b01111_100_0;

    always @(negedge clk) begin
        logic [8:0] exp_v;
        logic [8:0] act_v;
        bit dep;
        if (chk_on) begin
            dep = ex_is_load && ex_rd != 0 &&
                  ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
            check("state", state, m_busy);
            check("md_timeout", md_timeout, m_sticky);
            check("stall_cycles", stall_cycles, m_stall);

            if (!rstn) begin
                exp_v = V_RESET;
                m_busy = 0; m_waited = 0; m_sticky = 0; m_stall = 0;
            end else begin
                if (m_busy) begin
                    m_waited++;
                    if (md_done || m_waited == TO) begin
                        exp_v = V_GO;
                        if (!md_done) m_sticky = 1;
                        m_busy = 0;
                    end else begin
                        exp_v = V_MDHOLD;
                    end
                end else if (ex_branch_taken) exp_v = V_REDIR;
                else if (ex_md_op) begin
                    exp_v = V_MDHOLD | 9'b1;
                    m_busy = 1; m_waited = 0;
                end
                else if (dep) exp_v = V_LUSE;
                else if (!imem_ready) exp_v = V_FETCH;
                else exp_v = V_GO;
                if (!exp_v[8] && m_stall < SAT) m_stall++;
            end
            act_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush, md_start};
            check("ctrl_vector", act_v, exp_v);
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 5'd0; ex_is_load = 0; ex_md_op = 0; ex_branch_taken = 0;
        md_done = 0; imem_ready = 1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_is_load = 1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1;
        id_rs1 = 5'd3; id_uses_rs1 = 1;
    endtask

    initial begin
        rstn = 0;
        idle_inputs();
        @(posedge clk); #1;
        chk_on = 1;

        // reset held for two cycles
        @(negedge clk);
        check("rst_pc_en", pc_en, 0);
        check("rst_if_id_flush", if_id_flush, 1);
        check("rst_stall", stall_cycles, 0);
        step();
        rstn = 1;

        // idle
        repeat (3) step();
        @(negedge clk);
        check("idle_pc_en", pc_en, 1);
        check("idle_stall", stall_cycles, 0);
        step();

        // load-use on rs2
        set_load_use(5'd5);
        @(negedge clk);
        check("lu_pc_en", pc_en, 0);
        check("lu_if_id_en", if_id_en, 0);
        check("lu_id_ex_flush", id_ex_flush, 1);
        step();
        idle_inputs();
        @(negedge clk);
        check("lu_stall", stall_cycles, 1);
        check("lu_one_cycle", pc_en, 1);
        step();

        // load into x0 is not a hazard
        set_load_use(5'd0);
        @(negedge clk);
        check("lu_x0_pc_en", pc_en, 1);
        step();

        // branch beats load-use
        set_load_use(5'd5);
        ex_branch_taken = 1;
        @(negedge clk);
        check("br_pc_en", pc_en, 1);
        check("br_if_id_flush", if_id_flush, 1);
        check("br_id_ex_flush", id_ex_flush, 1);
        step();
        idle_inputs();
        @(negedge clk);
        check("br_stall", stall_cycles, 1);
        step();

        // mul/div, done on 4th wait cycle
        ex_md_op = 1;
        @(negedge clk);
        check("md_start_issue", md_start, 1);
        step();
        for (int i = 1; i <= 4; i++) begin
            md_done = (i == 4);
            @(negedge clk);
            check("md_wait_state", state, 1);
            check("md_start_once", md_start, 0);
            check("md_wait_pc_en", pc_en, (i == 4));
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("md_back_run", state, 0);
        check("md_stall", stall_cycles, 5);
        step();

        // timeout: md_done never comes
        ex_md_op = 1;
        step();
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            check("to_state", state, 1);
            check("to_pc_en", pc_en, (i == TO));
            step();
        end
        idle_inputs();
        md_done = 1;
        @(negedge clk);
        check("to_sticky", md_timeout, 1);
        check("to_stall", stall_cycles, 13);
        step();
        md_done = 0;
        @(negedge clk);
        check("to_done_ignored", state, 0);
        check("to_sticky_held", md_timeout, 1);
        step();

        // reset while in MD_WAIT
        ex_md_op = 1;
        step();
        step();
        rstn = 0;
        @(negedge clk);
        check("rmd_state_before", state, 1);
        check("rmd_md_start", md_start, 0);
        step();
        @(negedge clk);
        check("rmd_state_after", state, 0);
        check("rmd_timeout_clr", md_timeout, 0);
        rstn = 1;
        ex_md_op = 0;
        step();

        // md_done coincident with timeout: treated as done
        ex_md_op = 1;
        step();
        for (int i = 1; i <= TO; i++) begin
            md_done = (i == TO);
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("tie_no_timeout", md_timeout, 0);
        check("tie_state", state, 0);
        step();

        // minimum MD_WAIT occupancy of one cycle
        ex_md_op = 1;
        step();
        md_done = 1;
        @(negedge clk);
        check("min_state", state, 1);
        check("min_pc_en", pc_en, 1);
        step();
        idle_inputs();
        @(negedge clk);
        check("min_back_run", state, 0);
        step();

        // saturation of stall_cycles
        rstn = 0;
        step();
        rstn = 1;
        imem_ready = 0;
        repeat (20) step();
        @(negedge clk);
        check("sat_stall", stall_cycles, 15);
        check("sat_if_id_flush", if_id_flush, 1);
        imem_ready = 1;
        step();
        step();

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
